branch_resolve_unit: RTL and testbench

- Sits directly downstream of the BCOND comparator in the EX stage.
- Consumes BCOND's 3-bit compare result together with the decoded branch/jump info, and decides the actual next PC.
- Detects a mispredict against the PC that fetch actually followed, and issues a registered one-cycle redirect/flush to IF/ID.
- Owns a small 2-bit-counter branch history table (BHT) that IF reads for direction prediction; also keeps branch and mispredict statistics counters.

---
 rtl/branch_resolve_unit.sv | 181 ++++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution: decides the real next PC from BCOND and decode info,
// issues a registered redirect/exception pulse on mispredict, and owns the BHT read by IF.
module branch_resolve_unit #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BHT_ENTRIES = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_pred_taken,
    input  logic            ex_valid,
    input  logic            ex_stall,
    input  logic            ex_is_branch,
    input  logic            ex_is_jal,
    input  logic            ex_is_jalr,
    input  logic [2:0]      ex_funct3,
    input  logic [2:0]      ex_bcond,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_imm,
    input  logic [XLEN-1:0] ex_rs1,
    input  logic [XLEN-1:0] ex_fetched_npc,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            exc_valid,
    output logic [31:0]     br_count,
    output logic [31:0]     mispred_count
);

    localparam int unsigned IDX_W = (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;
    localparam int unsigned CNT_W = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_MAX = 2'b11;
    localparam logic [1:0] CTR_MIN = 2'b00;
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    logic [1:0] bht [BHT_ENTRIES];

    logic [IDX_W-1:0] if_idx;
    logic [IDX_W-1:0] ex_idx;

    // Decode and resolution (combinational)
    logic            consume;
    logic            sel_jalr;
    logic            sel_jal;
    logic            sel_branch;
    logic            br_taken;
    logic            illegal_f3;
    logic            taken;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] npc;
    logic            exc;
    logic            mispred;
    logic            bht_upd;
    logic [1:0]      bht_cur;
    logic [1:0]      bht_nxt;

    // Next-state of registered outputs
    logic             redirect_valid_n;
    logic [XLEN-1:0]  redirect_pc_n;
    logic             exc_valid_n;
    logic [CNT_W-1:0] br_count_n;
    logic [CNT_W-1:0] mispred_count_n;

    logic unused_pc_bits;

    assign if_idx         = if_pc[IDX_W+1:2];
    assign ex_idx         = ex_pc[IDX_W+1:2];
    assign if_pred_taken  = bht[if_idx][1];
    assign unused_pc_bits = ^{if_pc[XLEN-1:IDX_W+2], if_pc[1:0]};

    // Direction from BCOND flags: eq, signed A>B, unsigned A>B
    always_comb begin
        br_taken   = 1'b0;
        illegal_f3 = 1'b0;
        case (ex_funct3)
            F3_BEQ:  br_taken = ex_bcond[2];
            F3_BNE:  br_taken = ~ex_bcond[2];
            F3_BLT:  br_taken = ~ex_bcond[2] & ~ex_bcond[1];
            F3_BGE:  br_taken = ex_bcond[2] | ex_bcond[1];
            F3_BLTU: br_taken = ~ex_bcond[2] & ~ex_bcond[0];
            F3_BGEU: br_taken = ex_bcond[2] | ex_bcond[0];
            default: illegal_f3 = 1'b1;
        endcase
    end

    // Target, next PC, exception and mispredict; JALR > JAL > BRANCH
    always_comb begin
        consume    = ex_valid & ~ex_stall & ~redirect_valid;
        sel_jalr   = ex_is_jalr;
        sel_jal    = ex_is_jal & ~ex_is_jalr;
        sel_branch = ex_is_branch & ~ex_is_jal & ~ex_is_jalr;
        seq_pc     = ex_pc + XLEN'(4);
        target     = ex_pc + ex_imm;
        taken      = 1'b0;

        if (sel_jalr) begin
            target = (ex_rs1 + ex_imm) & ~XLEN'(1);
            taken  = 1'b1;
        end else if (sel_jal) begin
            taken  = 1'b1;
        end else if (sel_branch) begin
            taken  = br_taken & ~illegal_f3;
        end

        npc     = taken ? target : seq_pc;
        exc     = consume & ((sel_branch & illegal_f3) | (taken & target[1]));
        mispred = consume & ~exc & (npc != ex_fetched_npc);
        bht_upd = consume & ~exc & sel_branch;
    end

    // Saturating 2-bit counter step for the EX branch's entry
    always_comb begin
        bht_cur = bht[ex_idx];
        bht_nxt = bht_cur;
        if (br_taken) begin
            if (bht_cur != CTR_MAX) begin
                bht_nxt = bht_cur + 2'd1;
            end
        end else begin
            if (bht_cur != CTR_MIN) begin
                bht_nxt = bht_cur - 2'd1;
            end
        end
    end

    // Redirect/exception pulses and statistics counters
    always_comb begin
        redirect_valid_n = mispred;
        redirect_pc_n    = redirect_pc;
        exc_valid_n      = exc;
        br_count_n       = br_count;
        mispred_count_n  = mispred_count;

        if (mispred) begin
            redirect_pc_n = npc;
            if (mispred_count != CNT_SAT) begin
                mispred_count_n = mispred_count + CNT_W'(1);
            end
        end
        if (bht_upd && (br_count != CNT_SAT)) begin
            br_count_n = br_count + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            exc_valid      <= 1'b0;
            br_count       <= '0;
            mispred_count  <= '0;
        end else begin
            redirect_valid <= redirect_valid_n;
            redirect_pc    <= redirect_pc_n;
            exc_valid      <= exc_valid_n;
            br_count       <= br_count_n;
            mispred_count  <= mispred_count_n;
        end
    end

    // BHT resets to weakly not-taken; reads in IF see pre-update contents
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(BHT_ENTRIES); i++) begin
                bht[i] <= CTR_WNT;
            end
        end else if (bht_upd) begin
            bht[ex_idx] <= bht_nxt;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios plus randomized
// traffic checked against an operand-level reference model of branch resolution.
module tb_branch_resolve_unit;

    logic        clk;
    logic        reset;
    logic [31:0] if_pc;
    logic        if_pred_taken;
    logic        ex_valid;
    logic        ex_stall;
    logic        ex_is_branch;
    logic        ex_is_jal;
    logic        ex_is_jalr;
    logic [2:0]  ex_funct3;
    logic [2:0]  ex_bcond;
    logic [31:0] ex_pc;
    logic [31:0] ex_imm;
    logic [31:0] ex_rs1;
    logic [31:0] ex_fetched_npc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exc_valid;
    logic [31:0] br_count;
    logic [31:0] mispred_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Compare operands feeding the (modelled) BCOND unit
    logic [31:0] op_a;
    logic [31:0] op_b;

    // Reference model state
    bit          m_rv;
    bit          m_exc;
    logic [31:0] m_rpc;
    logic [31:0] m_br;
    logic [31:0] m_mp;
    logic [1:0]  m_bht [16];

    branch_resolve_unit dut (
        .clk            (clk),
        .reset          (reset),
        .if_pc          (if_pc),
        .if_pred_taken  (if_pred_taken),
        .ex_valid       (ex_valid),
        .ex_stall       (ex_stall),
        .ex_is_branch   (ex_is_branch),
        .ex_is_jal      (ex_is_jal),
        .ex_is_jalr     (ex_is_jalr),
        .ex_funct3      (ex_funct3),
        .ex_bcond       (ex_bcond),
        .ex_pc          (ex_pc),
        .ex_imm         (ex_imm),
        .ex_rs1         (ex_rs1),
        .ex_fetched_npc (ex_fetched_npc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exc_valid      (exc_valid),
        .br_count       (br_count),
        .mispred_count  (mispred_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
        op_a     = a;
        op_b     = b;
        ex_bcond = {a == b, $signed(a) > $signed(b), a > b};
    endtask

    task automatic drive_idle();
        ex_valid = 0; ex_stall = 0; ex_is_branch = 0; ex_is_jal = 0; ex_is_jalr = 0;
        ex_funct3 = 0; ex_pc = 0; ex_imm = 0; ex_rs1 = 0; ex_fetched_npc = 0;
        set_ops(32'd0, 32'd1);
    endtask

    task automatic drive_instr(input bit br, input bit jal, input bit jalr, input logic [2:0] f3,
                               input logic [31:0] pc, input logic [31:0] imm,
                               input logic [31:0] rs1, input logic [31:0] fetched);
        ex_valid = 1; ex_stall = 0;
        ex_is_branch = br; ex_is_jal = jal; ex_is_jalr = jalr;
        ex_funct3 = f3; ex_pc = pc; ex_imm = imm; ex_rs1 = rs1; ex_fetched_npc = fetched;
    endtask

    function automatic void model_reset();
        m_rv = 0; m_exc = 0; m_rpc = 0; m_br = 0; m_mp = 0;
        for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs
    function automatic void model_edge();
        bit          consume, tk, ill, is_cond, exc, mp;
        logic [31:0] tgt, npc;
        int          idx;
        consume = ex_valid && !ex_stall && !m_rv;
        tk = 0; ill = 0; is_cond = 0;
        tgt = ex_pc + ex_imm;
        if (ex_is_jalr) begin
            tgt = (ex_rs1 + ex_imm) & 32'hFFFF_FFFE;
            tk  = 1;
        end else if (ex_is_jal) begin
            tk = 1;
        end else if (ex_is_branch) begin
            is_cond = 1;
            case (ex_funct3)
                3'd0: tk = (op_a == op_b);
                3'd1: tk = (op_a != op_b);
                3'd4: tk = ($signed(op_a) <  $signed(op_b));
                3'd5: tk = ($signed(op_a) >= $signed(op_b));
                3'd6: tk = (op_a <  op_b);
                3'd7: tk = (op_a >= op_b);
                default: ill = 1;
            endcase
        end
        npc = tk ? tgt : ex_pc + 32'd4;
        exc = consume && (ill || (tk && tgt[1]));
        mp  = consume && !exc && (npc != ex_fetched_npc);
        if (consume && !exc && is_cond) begin
            idx = int'(ex_pc[5:2]);
            if (tk && m_bht[idx] != 2'b11) m_bht[idx] = m_bht[idx] + 2'd1;
            else if (!tk && m_bht[idx] != 2'b00) m_bht[idx] = m_bht[idx] - 2'd1;
            if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
        end
        if (mp) begin
            m_rpc = npc;
            if (m_mp != 32'hFFFF_FFFF) m_mp = m_mp + 1;
        end
        m_rv  = mp;
        m_exc = exc;
    endfunction

    task automatic test_reset();
        reset = 1;
        drive_idle();
        if_pc = 0;
        model_reset();
        #3;
        n_tests++;
        if (redirect_valid !== 1'b0 || exc_valid !== 1'b0 || redirect_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_async_outputs: rv=%b exc=%b rpc=%h, need 0/0/0", redirect_valid, exc_valid, redirect_pc);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        tick();
        n_tests++;
        if (br_count !== 32'd0 || mispred_count !== 32'd0 || redirect_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_counters: br=%0d mp=%0d rv=%b, need 0/0/0", br_count, mispred_count, redirect_valid);
        end
        for (int a = 0; a <= 32'h3C; a += 4) begin
            if_pc = 32'(a);
            #1;
            n_tests++;
            if (if_pred_taken !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_bht_pred: if_pc=%h got %b need 0", if_pc, if_pred_taken);
            end
        end
    endtask

    task automatic test_blt_mispredict();
        drive_instr(1, 0, 0, 3'b100, 32'h100, 32'h20, 32'h0, 32'h104);
        set_ops(32'd1, 32'd2);
        if_pc = 32'h100;
        #1;
        n_tests++;
        if (ex_bcond !== 3'b000 || if_pred_taken !== 1'b0) begin
            n_fail++;
            $display("FAIL blt_pre_pred: bcond=%b pred=%b, need 000/0", ex_bcond, if_pred_taken);
        end
        model_edge();
        tick();
        drive_idle();
        #1;
        n_tests++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h120 || mispred_count !== 32'd1 || br_count !== 32'd1) begin
            n_fail++;
            $display("FAIL blt_redirect: rv=%b rpc=%h mp=%0d br=%0d, need 1/00000120/1/1",
                     redirect_valid, redirect_pc, mispred_count, br_count);
        end
        n_tests++;
        if (if_pred_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL blt_bht_update: pred=%b need 1", if_pred_taken);
        end
        model_edge();
        tick();
        n_tests++;
        if (redirect_valid !== 1'b0 || redirect_pc !== 32'h120) begin
            n_fail++;
            $display("FAIL blt_pulse_clear: rv=%b rpc=%h, need 0/00000120", redirect_valid, redirect_pc);
        end
    endtask

    task automatic test_bgeu_and_shadow();
        drive_instr(1, 0, 0, 3'b111, 32'h200, 32'h40, 32'h0, 32'h240);
        set_ops(32'hFFFF_FFFF, 32'd0);
        model_edge();
        tick();
        n_tests++;
        if (redirect_valid !== 1'b0 || br_count !== 32'd2 || mispred_count !== 32'd1) begin
            n_fail++;
            $display("FAIL bgeu_predicted: rv=%b br=%0d mp=%0d, need 0/2/1", redirect_valid, br_count, mispred_count);
        end
        drive_instr(0, 0, 0, 3'b000, 32'h300, 32'h0, 32'h0, 32'h0);
        model_edge();
        tick();
        n_tests++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h304 || mispred_count !== 32'd2) begin
            n_fail++;
            $display("FAIL nonctl_redirect: rv=%b rpc=%h mp=%0d, need 1/00000304/2", redirect_valid, redirect_pc, mispred_count);
        end
        drive_instr(1, 0, 0, 3'b000, 32'h400, 32'h40, 32'h0, 32'h404);
        set_ops(32'd3, 32'd3);
        model_edge();
        tick();
        n_tests++;
        if (redirect_valid !== 1'b0 || redirect_pc !== 32'h304 || mispred_count !== 32'd2 ||
            br_count !== 32'd2 || exc_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL shadow_ignored: rv=%b rpc=%h mp=%0d br=%0d exc=%b, need 0/00000304/2/2/0",
                     redirect_valid, redirect_pc, mispred_count, br_count, exc_valid);
        end
        drive_idle();
    endtask

    task automatic test_jalr();
        drive_instr(0, 0, 1, 3'b000, 32'h500, 32'h4, 32'h1001, 32'h0);
        if_pc = 32'h500;
        model_edge();
        tick();
        drive_idle();
        n_tests++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h1004 || br_count !== 32'd2 || mispred_count !== 32'd3) begin
            n_fail++;
            $display("FAIL jalr_redirect: rv=%b rpc=%h br=%0d mp=%0d, need 1/00001004/2/3",
                     redirect_valid, redirect_pc, br_count, mispred_count);
        end
        n_tests++;
        if (if_pred_taken !== 1'b1) begin
            n_fail++;
            $display("FAIL jalr_bht_unchanged: pred=%b need 1", if_pred_taken);
        end
        model_edge();
        tick();
    endtask

    task automatic test_exceptions();
        drive_instr(1, 0, 0, 3'b010, 32'h600, 32'h8, 32'h0, 32'h0);
        set_ops(32'd9, 32'd9);
        model_edge();
        tick();
        drive_idle();
        n_tests++;
        if (exc_valid !== 1'b1 || redirect_valid !== 1'b0 || br_count !== 32'd2) begin
            n_fail++;
            $display("FAIL illegal_f3_exc: exc=%b rv=%b br=%0d, need 1/0/2", exc_valid, redirect_valid, br_count);
        end
        model_edge();
        tick();
        n_tests++;
        if (exc_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL exc_pulse_clear: exc=%b need 0", exc_valid);
        end
        drive_instr(1, 0, 0, 3'b000, 32'h100, 32'h2, 32'h0, 32'h104);
        set_ops(32'd5, 32'd5);
        model_edge();
        tick();
        drive_idle();
        n_tests++;
        if (exc_valid !== 1'b1 || redirect_valid !== 1'b0 || br_count !== 32'd2 || mispred_count !== 32'd3) begin
            n_fail++;
            $display("FAIL misaligned_exc: exc=%b rv=%b br=%0d mp=%0d, need 1/0/2/3",
                     exc_valid, redirect_valid, br_count, mispred_count);
        end
        model_edge();
        tick();
    endtask

    task automatic test_reset_mid_redirect();
        drive_instr(0, 0, 0, 3'b000, 32'h700, 32'h0, 32'h0, 32'h0);
        model_edge();
        tick();
        drive_idle();
        n_tests++;
        if (redirect_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_redirect: rv=%b need 1", redirect_valid);
        end
        #2;
        reset = 1;
        #1;
        n_tests++;
        if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0 || mispred_count !== 32'd0 || br_count !== 32'd0) begin
            n_fail++;
            $display("FAIL async_reset_drop: rv=%b rpc=%h mp=%0d br=%0d, need 0/0/0/0",
                     redirect_valid, redirect_pc, mispred_count, br_count);
        end
        #2;
        reset = 0;
        model_reset();
        tick();
    endtask

    task automatic test_saturation_wrap();
        for (int k = 0; k < 4; k++) begin
            drive_instr(1, 0, 0, 3'b000, 32'h40, 32'h10, 32'h0, 32'h50);
            set_ops(32'd7, 32'd7);
            model_edge();
            tick();
        end
        drive_idle();
        if_pc = 32'h40;
        #1;
        n_tests++;
        if (if_pred_taken !== 1'b1 || m_bht[0] !== 2'b11 || br_count !== 32'd4 || redirect_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bht_saturate: pred=%b br=%0d rv=%b, need 1/4/0", if_pred_taken, br_count, redirect_valid);
        end
        drive_instr(1, 0, 0, 3'b001, 32'hFFFF_FFFC, 32'h10, 32'h0, 32'h8);
        set_ops(32'd4, 32'd4);
        model_edge();
        tick();
        drive_idle();
        n_tests++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0 || exc_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pc_wrap: rv=%b rpc=%h exc=%b, need 1/00000000/0", redirect_valid, redirect_pc, exc_valid);
        end
        model_edge();
        tick();
    endtask

    task automatic test_random();
        logic [31:0] r;
        int          kind;
        for (int it = 0; it < 400; it++) begin
            kind = int'($urandom_range(0, 9));
            ex_is_branch = (kind <= 5) || (kind == 9 && $urandom_range(0, 1) == 1);
            ex_is_jal    = (kind == 6) || (kind == 9 && $urandom_range(0, 1) == 1);
            ex_is_jalr   = (kind == 7) || (kind == 9 && $urandom_range(0, 1) == 1);
            ex_valid     = ($urandom_range(0, 99) < 85);
            ex_stall     = ($urandom_range(0, 99) < 15);
            ex_funct3    = 3'($urandom_range(0, 7));
            r            = $urandom;
            ex_pc        = r & 32'hFFFF_FFFC;
            r            = $urandom;
            ex_imm       = {{20{r[11]}}, r[11:1], 1'b0};
            ex_rs1       = $urandom;
            case ($urandom_range(0, 3))
                0, 1:    ex_fetched_npc = ex_pc + 32'd4;
                2:       ex_fetched_npc = ex_is_jalr ? ((ex_rs1 + ex_imm) & 32'hFFFF_FFFE) : ex_pc + ex_imm;
                default: ex_fetched_npc = $urandom;
            endcase
            r = $urandom;
            if ($urandom_range(0, 3) == 0) set_ops(r, r);
            else set_ops(r, $urandom);
            r     = $urandom;
            if_pc = ($urandom_range(0, 1) == 1) ? ex_pc : r;
            #1;
            n_tests++;
            if (if_pred_taken !== m_bht[int'(if_pc[5:2])][1]) begin
                n_fail++;
                $display("FAIL rand_pred[%0d]: if_pc=%h got %b need %b", it, if_pc, if_pred_taken, m_bht[int'(if_pc[5:2])][1]);
            end
            model_edge();
            tick();
            n_tests++;
            if (redirect_valid !== m_rv || redirect_pc !== m_rpc || exc_valid !== m_exc ||
                br_count !== m_br || mispred_count !== m_mp) begin
                n_fail++;
                $display("FAIL rand_resolve[%0d]: rv=%b rpc=%h exc=%b br=%0d mp=%0d, need %b/%h/%b/%0d/%0d",
                         it, redirect_valid, redirect_pc, exc_valid, br_count, mispred_count,
                         m_rv, m_rpc, m_exc, m_br, m_mp);
            end
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_blt_mispredict();
        test_bgeu_and_shadow();
        test_jalr();
        test_exceptions();
        test_reset_mid_redirect();
        test_saturation_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
